// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch (IFU) and load/store (LSU).
// One transaction in flight; round-robin on ties; response watchdog with sticky bus_err.
//
// state  | meaning
// S_IDLE | arbitrate, accept one request (readies are combinational)
// S_REQ  | present latched request downstream until mem_req_ready
// S_WAIT | wait for mem_rsp_valid or watchdog expiry, then pulse owner's rsp_valid
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] ifu_addr,
    output logic                  ifu_rsp_valid,
    output logic [DATA_WIDTH-1:0] ifu_rdata,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic                  lsu_wen,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    input  logic [MASK_WIDTH-1:0] lsu_wmask,
    output logic                  lsu_rsp_valid,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wen,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [MASK_WIDTH-1:0] mem_wmask,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  last_lsu_q, last_lsu_d;
    logic                  owner_lsu_q, owner_lsu_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wen_q, wen_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [MASK_WIDTH-1:0] wmask_q, wmask_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  bus_err_q, bus_err_d;
    logic                  ifu_rsp_valid_q, ifu_rsp_valid_d;
    logic                  lsu_rsp_valid_q, lsu_rsp_valid_d;
    logic [DATA_WIDTH-1:0] ifu_rdata_q, ifu_rdata_d;
    logic [DATA_WIDTH-1:0] lsu_rdata_q, lsu_rdata_d;
    logic                  grant_ifu, grant_lsu;

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (state_q == S_IDLE) begin
            if (ifu_req_valid && (!lsu_req_valid || last_lsu_q)) begin
                grant_ifu = 1'b1;
            end else if (lsu_req_valid) begin
                grant_lsu = 1'b1;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        last_lsu_d      = last_lsu_q;
        owner_lsu_d     = owner_lsu_q;
        addr_d          = addr_q;
        wen_d           = wen_q;
        wdata_d         = wdata_q;
        wmask_d         = wmask_q;
        cnt_d           = cnt_q;
        bus_err_d       = bus_err_q;
        ifu_rsp_valid_d = 1'b0;
        lsu_rsp_valid_d = 1'b0;
        ifu_rdata_d     = ifu_rdata_q;
        lsu_rdata_d     = lsu_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (grant_ifu) begin
                    addr_d      = ifu_addr;
                    wen_d       = 1'b0;
                    wdata_d     = '0;
                    wmask_d     = '0;
                    owner_lsu_d = 1'b0;
                    last_lsu_d  = 1'b0;
                    state_d     = S_REQ;
                end else if (grant_lsu) begin
                    addr_d      = lsu_addr;
                    wen_d       = lsu_wen;
                    wdata_d     = lsu_wdata;
                    wmask_d     = lsu_wmask;
                    owner_lsu_d = 1'b1;
                    last_lsu_d  = 1'b1;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // cnt_q never exceeds TIMEOUT-1 here, so the increment cannot wrap.
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_rsp_valid) begin
                    state_d = S_IDLE;
                    if (owner_lsu_q) begin
                        lsu_rdata_d     = mem_rdata;
                        lsu_rsp_valid_d = 1'b1;
                    end else begin
                        ifu_rdata_d     = mem_rdata;
                        ifu_rsp_valid_d = 1'b1;
                    end
                end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                    state_d   = S_IDLE;
                    bus_err_d = 1'b1;
                    if (owner_lsu_q) begin
                        lsu_rdata_d     = '0;
                        lsu_rsp_valid_d = 1'b1;
                    end else begin
                        ifu_rdata_d     = '0;
                        ifu_rsp_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            last_lsu_q      <= 1'b1;
            owner_lsu_q     <= 1'b0;
            addr_q          <= '0;
            wen_q           <= 1'b0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            cnt_q           <= '0;
            bus_err_q       <= 1'b0;
            ifu_rsp_valid_q <= 1'b0;
            lsu_rsp_valid_q <= 1'b0;
            ifu_rdata_q     <= '0;
            lsu_rdata_q     <= '0;
        end else begin
            state_q         <= state_d;
            last_lsu_q      <= last_lsu_d;
            owner_lsu_q     <= owner_lsu_d;
            addr_q          <= addr_d;
            wen_q           <= wen_d;
            wdata_q         <= wdata_d;
            wmask_q         <= wmask_d;
            cnt_q           <= cnt_d;
            bus_err_q       <= bus_err_d;
            ifu_rsp_valid_q <= ifu_rsp_valid_d;
            lsu_rsp_valid_q <= lsu_rsp_valid_d;
            ifu_rdata_q     <= ifu_rdata_d;
            lsu_rdata_q     <= lsu_rdata_d;
        end
    end

    assign ifu_req_ready = grant_ifu;
    assign lsu_req_ready = grant_lsu;
    assign mem_req_valid = (state_q == S_REQ);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;
    assign ifu_rsp_valid = ifu_rsp_valid_q;
    assign lsu_rsp_valid = lsu_rsp_valid_q;
    assign ifu_rdata     = ifu_rdata_q;
    assign lsu_rdata     = lsu_rdata_q;
    assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, hand-written corner sequences,
// and randomized transactions checked against a transaction-level model.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [AW-1:0] ifu_addr;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata, lsu_rdata;
    logic [MW-1:0] lsu_wmask;
    logic          mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, bus_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [MW-1:0] mem_wmask;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          iv, lv, wen;
        logic [AW-1:0] a_i, a_l;
        logic [DW-1:0] wd;
        logic [MW-1:0] wm;
        logic [DW-1:0] md;
        int            stall, lat;
        logic          exp_ri, exp_rl;
    } vec_t;

    int n_checks = 0;
    int n_err    = 0;

    // Transaction-level reference state.
    bit            m_last_lsu;
    bit            m_bus_err, m_pend, m_pend_lsu;
    logic [DW-1:0] m_ifu_rdata, m_lsu_rdata;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        m_last_lsu  = 1'b1;
        m_bus_err   = 1'b0;
        m_pend      = 1'b0;
        m_pend_lsu  = 1'b0;
        m_ifu_rdata = '0;
        m_lsu_rdata = '0;
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_ctl"}, 64'({mem_req_valid, ifu_req_ready, lsu_req_ready, ifu_rsp_valid,
                                 lsu_rsp_valid, mem_wen, bus_err}), 64'(0));
        check({nm, "_mem_addr"}, 64'(mem_addr), 64'(0));
        check({nm, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
        check({nm, "_mem_wmask"}, 64'(mem_wmask), 64'(0));
        check({nm, "_rdata"}, {ifu_rdata, lsu_rdata}, 64'(0));
    endtask

    task automatic drive_quiet();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
    endtask

    task automatic do_reset();
        drive_quiet();
        rst = 1'b0;
        #1;
        check_all_zero("reset");
        reset_model();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Called at the negedge of a cycle in which the arbiter should be idle.
    task automatic check_idle();
        check("ifu_rsp_valid", 64'(ifu_rsp_valid), 64'(m_pend && !m_pend_lsu));
        check("lsu_rsp_valid", 64'(lsu_rsp_valid), 64'(m_pend && m_pend_lsu));
        check("ifu_rdata", 64'(ifu_rdata), 64'(m_ifu_rdata));
        check("lsu_rdata", 64'(lsu_rdata), 64'(m_lsu_rdata));
        check("bus_err", 64'(bus_err), 64'(m_bus_err));
        check("mem_req_valid_idle", 64'(mem_req_valid), 64'(0));
        m_pend = 1'b0;
    endtask

    task automatic idle_cycle();
        drive_quiet();
        @(negedge clk);
        check_idle();
        check("ready_idle", 64'({ifu_req_ready, lsu_req_ready}), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_reqs();
        ifu_req_valid = 1'($urandom_range(0, 1));
        lsu_req_valid = 1'($urandom_range(0, 1));
        ifu_addr      = $urandom;
        lsu_addr      = $urandom;
        lsu_wdata     = $urandom;
        lsu_wmask     = 8'($urandom);
        lsu_wen       = 1'($urandom_range(0, 1));
    endtask

    // Starts #1 after a posedge in an idle cycle; ends #1 after the edge that raises rsp_valid.
    task automatic run_txn(input vec_t v);
        logic          own_lsu, e_wen, tmo;
        logic [AW-1:0] e_addr;
        logic [MW-1:0] e_wm;
        int            nw;
        ifu_req_valid = v.iv;  ifu_addr = v.a_i;
        lsu_req_valid = v.lv;  lsu_addr = v.a_l;
        lsu_wen = v.wen;  lsu_wdata = v.wd;  lsu_wmask = v.wm;
        mem_req_ready = 1'b0;  mem_rsp_valid = 1'b0;
        @(negedge clk);
        check_idle();
        check("ifu_req_ready", 64'(ifu_req_ready), 64'(v.exp_ri));
        check("lsu_req_ready", 64'(lsu_req_ready), 64'(v.exp_rl));
        own_lsu    = v.exp_rl;
        m_last_lsu = v.exp_rl;
        e_addr = own_lsu ? v.a_l : v.a_i;
        e_wen  = own_lsu & v.wen;
        e_wm   = own_lsu ? v.wm : '0;
        @(posedge clk);
        #1;
        for (int s = 0; s <= v.stall; s++) begin
            scramble_reqs();
            mem_req_ready = (s == v.stall);
            mem_rsp_valid = 1'($urandom_range(0, 1));
            mem_rdata     = $urandom;
            @(negedge clk);
            check("mem_req_valid", 64'(mem_req_valid), 64'(1));
            check("mem_addr", 64'(mem_addr), 64'(e_addr));
            check("mem_wen", 64'(mem_wen), 64'(e_wen));
            check("mem_wmask", 64'(mem_wmask), 64'(e_wm));
            if (own_lsu) check("mem_wdata", 64'(mem_wdata), 64'(v.wd));
            check("ready_in_req", 64'({ifu_req_ready, lsu_req_ready}), 64'(0));
            check("rsp_in_req", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'(0));
            @(posedge clk);
            #1;
        end
        tmo = (v.lat >= TO);
        nw  = tmo ? TO : v.lat + 1;
        for (int k = 0; k < nw; k++) begin
            scramble_reqs();
            mem_req_ready = 1'($urandom_range(0, 1));
            mem_rsp_valid = (k == v.lat);
            mem_rdata     = (k == v.lat) ? v.md : $urandom;
            @(negedge clk);
            check("mem_req_valid_wait", 64'(mem_req_valid), 64'(0));
            check("ready_in_wait", 64'({ifu_req_ready, lsu_req_ready}), 64'(0));
            check("rsp_early", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'(0));
            check("bus_err_wait", 64'(bus_err), 64'(m_bus_err));
            @(posedge clk);
            #1;
        end
        drive_quiet();
        m_pend     = 1'b1;
        m_pend_lsu = own_lsu;
        if (tmo) m_bus_err = 1'b1;
        if (own_lsu) m_lsu_rdata = tmo ? '0 : v.md;
        else         m_ifu_rdata = tmo ? '0 : v.md;
    endtask

    vec_t tbl[9];
    vec_t v;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ifu_addr = '0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        mem_rdata = '0;
        //             iv   lv   wen  a_i           a_l           wd            wm     md            st lat ri   rl
        tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h8000_0004, 32'h8000_1000, 32'h0,        8'h00, 32'h1111_0001, 0, 0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h8000_0008, 32'h8000_1004, 32'h0,        8'h00, 32'h2222_0002, 1, 1, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h8000_000C, 32'h8000_1008, 32'hCAFE_F00D, 8'hFF, 32'h3333_0003, 0, 2, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h8000_0010, 32'h8000_100C, 32'h0,        8'h00, 32'h4444_0004, 2, 3, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h8000_0014, 32'h8000_1010, 32'h0,        8'h00, 32'h5555_0005, 0, 0, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 32'h8000_0018, 32'h8000_1014, 32'h0,        8'h00, 32'h6666_0006, 0, 3, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h8000_001C, 32'h8000_1018, 32'h0BAD_BEEF, 8'h3C, 32'h7777_0007, 1, 0, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 32'h8000_0020, 32'h8000_101C, 32'h1234_5678, 8'hF0, 32'h8888_0008, 0, 1, 1'b0, 1'b1};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 32'h8000_0024, 32'h8000_1020, 32'h0,        8'h00, 32'h9999_0009, 0, 0, 1'b1, 1'b0};

        do_reset();

        // IFU alone, minimum latency: accept at 0, mem_req at 1, mem_rsp at 2, pulse at 3.
        v = '{1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 8'h00, 32'h0000_0413, 0, 0, 1'b1, 1'b0};
        run_txn(v);
        idle_cycle();
        check("plan1_ifu_rdata", 64'(ifu_rdata), 64'(32'h0000_0413));

        // Round-robin table from reset; each transaction starts in the previous pulse cycle.
        do_reset();
        for (int i = 0; i < 9; i++) run_txn(tbl[i]);
        idle_cycle();

        // LSU write held in REQ for 5 cycles of mem_req_ready=0.
        v = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h8000_0100, 32'hDEAD_BEEF, 8'h0F, 32'h0, 5, 0, 1'b0, 1'b1};
        run_txn(v);
        idle_cycle();

        // Memory never responds: timeout, then a normal LSU read with bus_err still set.
        v = '{1'b1, 1'b0, 1'b0, 32'h8000_0200, 32'h0, 32'h0, 8'h00, 32'hFFFF_FFFF, 0, 9, 1'b1, 1'b0};
        run_txn(v);
        v = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h8000_0300, 32'h0, 8'h00, 32'hABCD_0123, 1, 1, 1'b0, 1'b1};
        run_txn(v);
        idle_cycle();
        check("bus_err_sticky", 64'(bus_err), 64'(1));

        // Reset asserted while waiting for the response; a late response must be ignored.
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0040;
        @(posedge clk); #1;
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        @(negedge clk);
        check("wait_addr_before_rst", 64'(mem_addr), 64'(32'h8000_0040));
        #1;
        rst = 1'b0;
        #1;
        check_all_zero("rst_in_wait");
        reset_model();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h1234_5678;
        @(negedge clk);
        check_idle();
        @(posedge clk); #1;
        idle_cycle();
        idle_cycle();

        // Randomized transactions against the model.
        do_reset();
        for (int t = 0; t < 300; t++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) idle_cycle();
            v.iv = 1'($urandom_range(0, 1));
            v.lv = v.iv ? 1'($urandom_range(0, 1)) : 1'b1;
            v.wen = 1'($urandom_range(0, 1));
            v.a_i = $urandom;  v.a_l = $urandom;
            v.wd  = $urandom;  v.wm  = 8'($urandom);
            v.md  = $urandom;
            v.stall = $urandom_range(0, 3);
            v.lat   = ($urandom_range(0, 9) == 0) ? 6 : $urandom_range(0, 3);
            v.exp_rl = v.lv && (!v.iv || !m_last_lsu);
            v.exp_ri = v.iv && !v.exp_rl;
            run_txn(v);
        end
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
